// File: rtl/hist_pkg.sv
// Shared types and helpers for the parametrised histogram engine.
package hist_pkg;

  typedef enum logic [1:0] {CLEAR, ACCUM, DUMP} state_e;

  function automatic int nbins(input int bin_w);
    return 1 << bin_w;
  endfunction

  // Holds at maxv; callers detect saturation by comparing against maxv themselves.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] maxv);
    return (v >= maxv) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hist_bin_map.sv
// Maps a sample to its bin index and flags whether it lies inside the binned range.
module hist_bin_map #(
  parameter int DATA_W = 16,
  parameter int BIN_W  = 4,
  parameter int SHIFT  = 8
) (
  input  logic [DATA_W-1:0] data_in,
  output logic              in_range,
  output logic [BIN_W-1:0]  bin
);

  assign bin = data_in[SHIFT+BIN_W-1:SHIFT];

  generate
    if (SHIFT + BIN_W == DATA_W) begin : g_full
      assign in_range = 1'b1;
    end else begin : g_part
      assign in_range = (data_in[DATA_W-1:SHIFT+BIN_W] == '0);
    end
    if (SHIFT > 0) begin : g_lsb
      logic unused_lsb;
      assign unused_lsb = ^data_in[SHIFT-1:0];
    end
  endgenerate

endmodule

// File: rtl/hist_engine_param.sv
// Streaming histogram: saturating bin counters, out-of-range tally and a
// valid/ready readout sweep with optional clear-on-read.
module hist_engine_param
  import hist_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int BIN_W  = 4,
  parameter int SHIFT  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              write_en,
  output logic              ready,
  input  logic              dump_req,
  input  logic              clear_on_read,
  output logic [CNT_W-1:0]  data_out,
  output logic [BIN_W-1:0]  bin_idx,
  output logic              valid_out,
  input  logic              out_ready,
  output logic              last_bin,
  output logic [CNT_W-1:0]  oor_count,
  output logic              sat_flag
);

  localparam int               NBINS = nbins(BIN_W);
  localparam logic [CNT_W-1:0] CMAX  = '1;
  localparam logic [BIN_W-1:0] LAST  = '1;

  state_e             state_q;
  logic [BIN_W-1:0]   ptr_q;
  logic               cor_q;
  logic [CNT_W-1:0]   oor_q;
  logic               sat_q;
  logic [CNT_W-1:0]   cnt_q [NBINS];

  logic               in_range;
  logic [BIN_W-1:0]   bin;
  logic [CNT_W-1:0]   bin_inc_d;
  logic [CNT_W-1:0]   oor_inc_d;

  hist_bin_map #(
    .DATA_W (DATA_W),
    .BIN_W  (BIN_W),
    .SHIFT  (SHIFT)
  ) u_map (
    .data_in  (data_in),
    .in_range (in_range),
    .bin      (bin)
  );

  assign bin_inc_d = CNT_W'(sat_inc(32'(cnt_q[bin]), 32'(CMAX)));
  assign oor_inc_d = CNT_W'(sat_inc(32'(oor_q), 32'(CMAX)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      cor_q   <= 1'b0;
      oor_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      case (state_q)
        CLEAR: begin
          oor_q <= '0;
          sat_q <= 1'b0;
          ptr_q <= ptr_q + BIN_W'(1);
          if (ptr_q == LAST) state_q <= ACCUM;
        end
        ACCUM: begin
          if (write_en) begin
            if (in_range) begin
              if (cnt_q[bin] == CMAX) sat_q <= 1'b1;
            end else if (oor_q == CMAX) begin
              sat_q <= 1'b1;
            end else begin
              oor_q <= oor_inc_d;
            end
          end
          if (dump_req) begin
            state_q <= DUMP;
            cor_q   <= clear_on_read;
            ptr_q   <= '0;
          end
        end
        DUMP: begin
          if (out_ready) begin
            ptr_q <= ptr_q + BIN_W'(1);
            if (ptr_q == LAST) begin
              state_q <= ACCUM;
              if (cor_q) begin
                oor_q <= '0;
                sat_q <= 1'b0;
              end
            end
          end
        end
        default: state_q <= CLEAR;
      endcase
    end
  end

  // Counter storage carries no reset; the CLEAR sweep that follows every reset zeroes it.
  always_ff @(posedge clk) begin
    case (state_q)
      CLEAR:   cnt_q[ptr_q] <= '0;
      ACCUM:   if (write_en && in_range) cnt_q[bin] <= bin_inc_d;
      DUMP:    if (out_ready && cor_q) cnt_q[ptr_q] <= '0;
      default: ;
    endcase
  end

  assign ready     = (state_q == ACCUM);
  assign valid_out = (state_q == DUMP);
  assign bin_idx   = valid_out ? ptr_q : '0;
  assign data_out  = valid_out ? cnt_q[ptr_q] : '0;
  assign last_bin  = valid_out && (ptr_q == LAST);
  assign oor_count = oor_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_hist_engine_param.sv
// Randomised scoreboard bench for hist_engine_param (4-bit counters so saturation is reachable).
module tb_hist_engine_param;

  localparam int DATA_W = 16;
  localparam int BIN_W  = 4;
  localparam int SHIFT  = 8;
  localparam int CNT_W  = 4;
  localparam int NB     = 16;
  localparam int MAXC   = 15;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic              write_en = 1'b0;
  logic              ready;
  logic              dump_req = 1'b0;
  logic              clear_on_read = 1'b0;
  logic [CNT_W-1:0]  data_out;
  logic [BIN_W-1:0]  bin_idx;
  logic              valid_out;
  logic              out_ready = 1'b0;
  logic              last_bin;
  logic [CNT_W-1:0]  oor_count;
  logic              sat_flag;

  hist_engine_param #(
    .DATA_W (DATA_W),
    .BIN_W  (BIN_W),
    .SHIFT  (SHIFT),
    .CNT_W  (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .data_in       (data_in),
    .write_en      (write_en),
    .ready         (ready),
    .dump_req      (dump_req),
    .clear_on_read (clear_on_read),
    .data_out      (data_out),
    .bin_idx       (bin_idx),
    .valid_out     (valid_out),
    .out_ready     (out_ready),
    .last_bin      (last_bin),
    .oor_count     (oor_count),
    .sat_flag      (sat_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    int idx;
    int cnt;
    bit last;
  } beat_t;

  beat_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    mcnt[NB];
  int    moor;
  bit    msat;

  function automatic void check(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endfunction

  // Reference histogram: a sample belongs to bin (s / 2**SHIFT) when it is below 2**(SHIFT+BIN_W).
  function automatic void model_write(input int s);
    int b;
    if (s < (1 << (SHIFT + BIN_W))) begin
      b = s / (1 << SHIFT);
      if (mcnt[b] == MAXC) msat = 1'b1;
      else mcnt[b] = mcnt[b] + 1;
    end else begin
      if (moor == MAXC) msat = 1'b1;
      else moor = moor + 1;
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NB; i++) mcnt[i] = 0;
    moor = 0;
    msat = 1'b0;
  endfunction

  always @(negedge clk) begin
    if (!reset && valid_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", 1, 0);
      end else begin
        check("beat_idx", int'(bin_idx), exp_q[0].idx);
        check("beat_data", int'(data_out), exp_q[0].cnt);
        check("beat_last", int'(last_bin), int'(exp_q[0].last));
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_reset();
    write_en  = 1'b0;
    dump_req  = 1'b0;
    out_ready = 1'b0;
    reset     = 1'b1;
    exp_q.delete();
    model_clear();
    #1;
    check("rst_ready", int'(ready), 0);
    check("rst_valid", int'(valid_out), 0);
    check("rst_last", int'(last_bin), 0);
    check("rst_data", int'(data_out), 0);
    check("rst_idx", int'(bin_idx), 0);
    check("rst_oor", int'(oor_count), 0);
    check("rst_sat", int'(sat_flag), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    for (int k = 0; k < NB; k++) begin
      check("clear_ready_low", int'(ready), 0);
      @(posedge clk);
      #1;
    end
    check("accum_ready_high", int'(ready), 1);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!ready) check("wait_ready_timeout", 0, 1);
  endtask

  task automatic wr(input int s);
    wait_ready();
    write_en = 1'b1;
    data_in  = DATA_W'(s);
    model_write(s);
    @(posedge clk);
    #1;
    write_en = 1'b0;
  endtask

  task automatic dump(input bit cor, input bit rnd_rdy, input int stall_at, input int abort_at,
                      input bit wr_with, input int wr_s);
    int n = 0;
    bit stalled = 1'b0;
    beat_t bt;
    wait_ready();
    dump_req      = 1'b1;
    clear_on_read = cor;
    if (wr_with) begin
      write_en = 1'b1;
      data_in  = DATA_W'(wr_s);
      model_write(wr_s);
    end
    for (int i = 0; i < NB; i++) begin
      bt.idx  = i;
      bt.cnt  = mcnt[i];
      bt.last = (i == NB - 1);
      exp_q.push_back(bt);
    end
    if (cor) model_clear();
    @(posedge clk);
    #1;
    dump_req      = 1'b0;
    write_en      = 1'b0;
    clear_on_read = ~cor;
    check("dump_latency_valid", int'(valid_out), 1);
    check("dump_ready_low", int'(ready), 0);
    while (exp_q.size() != 0 && n < 400) begin
      if (abort_at >= 0 && int'(bin_idx) == abort_at) begin
        do_reset();
        return;
      end
      if (stall_at >= 0 && !stalled && int'(bin_idx) == stall_at) begin
        stalled   = 1'b1;
        out_ready = 1'b0;
        write_en  = 1'b1;
        data_in   = 16'h0600;
        repeat (4) begin
          @(posedge clk);
          #1;
          n++;
        end
        write_en = 1'b0;
        check("stall_idx_held", int'(bin_idx), stall_at);
      end else begin
        out_ready     = rnd_rdy ? ($urandom_range(0, 2) != 0) : 1'b1;
        write_en      = $urandom_range(0, 1) == 1;
        data_in       = DATA_W'($urandom);
        dump_req      = $urandom_range(0, 1) == 1;
        clear_on_read = $urandom_range(0, 1) == 1;
        @(posedge clk);
        #1;
        n++;
      end
    end
    out_ready = 1'b0;
    write_en  = 1'b0;
    dump_req  = 1'b0;
    if (exp_q.size() != 0) begin
      check("dump_timeout_beats_left", exp_q.size(), 0);
      exp_q.delete();
    end
    check("dump_end_valid", int'(valid_out), 0);
    check("dump_end_ready", int'(ready), 1);
    check("dump_end_oor", int'(oor_count), moor);
    check("dump_end_sat", int'(sat_flag), int'(msat));
  endtask

  function automatic int rand_sample();
    int r;
    r = $urandom_range(0, 3);
    if (r == 0) return int'($urandom_range(0, 65535));
    return ($urandom_range(0, 4) << SHIFT) | $urandom_range(0, 255);
  endfunction

  initial begin
    #3000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nw;
    // Reset, clear sweep timing, empty dump.
    do_reset();
    dump(1'b0, 1'b0, -1, -1, 1'b0, 0);

    // Known pattern, non-clearing dumps twice.
    repeat (5) wr(16'h0300);
    repeat (2) wr(16'h0F00);
    wr(16'h1000);
    check("t2_oor_const", int'(oor_count), 1);
    dump(1'b0, 1'b0, -1, -1, 1'b0, 0);
    dump(1'b0, 1'b1, -1, -1, 1'b0, 0);

    // Same pattern, clearing dump then verify empty.
    do_reset();
    repeat (5) wr(16'h0300);
    repeat (2) wr(16'h0F00);
    wr(16'h1000);
    dump(1'b1, 1'b0, -1, -1, 1'b0, 0);
    check("t3_oor_cleared", int'(oor_count), 0);
    dump(1'b0, 1'b0, -1, -1, 1'b0, 0);

    // Saturation of a 4-bit bin, sticky flag.
    do_reset();
    repeat (20) wr(16'h0200);
    check("t4_sat_set", int'(sat_flag), 1);
    dump(1'b0, 1'b0, -1, -1, 1'b0, 0);
    wr(16'h0100);
    check("t4_sat_sticky", int'(sat_flag), 1);
    dump(1'b1, 1'b0, -1, -1, 1'b0, 0);

    // Stall at bin 6 with a dropped sample, then re-read.
    repeat (2) wr(16'h0600);
    dump(1'b0, 1'b0, 6, -1, 1'b0, 0);
    dump(1'b0, 1'b0, -1, -1, 1'b0, 0);

    // Reset in the middle of a dump.
    repeat (3) wr(16'h0500);
    dump(1'b0, 1'b0, -1, 9, 1'b0, 0);
    dump(1'b0, 1'b0, -1, -1, 1'b0, 0);

    // Randomised traffic.
    for (int r = 0; r < 10; r++) begin
      nw = $urandom_range(5, 60);
      for (int k = 0; k < nw; k++) begin
        if ($urandom_range(0, 4) == 0) begin
          @(posedge clk);
          #1;
        end
        wr(rand_sample());
      end
      dump($urandom_range(0, 1) == 1, 1'b1, -1, -1, $urandom_range(0, 1) == 1, rand_sample());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
